// File: rtl/ufm_store_ctrl_if.sv
// Handshake bundle between a store requester / flash pins and the UFM store controller.
interface ufm_store_ctrl_if;
   logic       start;
   logic       ufmbusyn;
   logic       ufmfail;
   logic       storen;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] err_code;

   modport master (
      output start, ufmbusyn, ufmfail,
      input  storen, busy, done, err, err_code
   );

   modport slave (
      input  start, ufmbusyn, ufmfail,
      output storen, busy, done, err, err_code
   );
endinterface

// File: rtl/ufm_store_ctrl.sv
// UFM store sequencer: issues a timed STOREN strobe, then tracks the flash busy
// handshake with timeouts and fail detection, reporting DONE/ERR per operation.
module ufm_store_ctrl #(
   parameter int PULSE_CYC    = 120,
   parameter int BUSY_TO_CYC  = 400,
   parameter int READY_TO_CYC = 1000
) (
   input logic              clk,
   input logic              rstn,
   ufm_store_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE,
      PULSE,
      WAIT_BUSY,
      WAIT_READY,
      FINISH
   } state_t;

   localparam logic [15:0] PULSE_LAST    = 16'(PULSE_CYC - 1);
   localparam logic [15:0] BUSY_TO_LAST  = 16'(BUSY_TO_CYC - 1);
   localparam logic [15:0] READY_TO_LAST = 16'(READY_TO_CYC - 1);

   state_t      state;
   logic [15:0] cnt;
   logic [15:0] cnt_inc;
   logic        busy_meta, busy_s;
   logic        fail_meta, fail_s;
   logic        storen_q, busy_q, done_q, err_q;
   logic [1:0]  err_code_q;

   // Both flash flags are asynchronous; reset values match an idle, healthy flash.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         busy_meta <= 1'b1;
         busy_s    <= 1'b1;
         fail_meta <= 1'b0;
         fail_s    <= 1'b0;
      end else begin
         busy_meta <= bus.ufmbusyn;
         busy_s    <= busy_meta;
         fail_meta <= bus.ufmfail;
         fail_s    <= fail_meta;
      end
   end

   assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= IDLE;
         cnt        <= 16'd0;
         storen_q   <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= 2'b00;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start && busy_s) begin
                  state      <= PULSE;
                  cnt        <= 16'd0;
                  storen_q   <= 1'b0;
                  busy_q     <= 1'b1;
                  err_q      <= 1'b0;
                  err_code_q <= 2'b00;
               end
            end
            PULSE: begin
               if (cnt == PULSE_LAST) begin
                  state    <= WAIT_BUSY;
                  cnt      <= 16'd0;
                  storen_q <= 1'b1;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            // A fail indication outranks both a busy edge and a timeout.
            WAIT_BUSY: begin
               if (fail_s) begin
                  state      <= FINISH;
                  cnt        <= 16'd0;
                  done_q     <= 1'b1;
                  err_q      <= 1'b1;
                  err_code_q <= 2'b11;
               end else if (!busy_s) begin
                  state <= WAIT_READY;
                  cnt   <= 16'd0;
               end else if (cnt == BUSY_TO_LAST) begin
                  state      <= FINISH;
                  cnt        <= 16'd0;
                  done_q     <= 1'b1;
                  err_q      <= 1'b1;
                  err_code_q <= 2'b01;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            WAIT_READY: begin
               if (fail_s) begin
                  state      <= FINISH;
                  cnt        <= 16'd0;
                  done_q     <= 1'b1;
                  err_q      <= 1'b1;
                  err_code_q <= 2'b11;
               end else if (busy_s) begin
                  state  <= FINISH;
                  cnt    <= 16'd0;
                  done_q <= 1'b1;
               end else if (cnt == READY_TO_LAST) begin
                  state      <= FINISH;
                  cnt        <= 16'd0;
                  done_q     <= 1'b1;
                  err_q      <= 1'b1;
                  err_code_q <= 2'b10;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            FINISH: begin
               state  <= IDLE;
               cnt    <= 16'd0;
               busy_q <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               cnt      <= 16'd0;
               storen_q <= 1'b1;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.storen   = storen_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_ufm_store_ctrl.sv
// Randomized bench for ufm_store_ctrl: a per-operation timing predictor derives
// DONE cycle, STOREN width and error code from the flash pin schedule.
module tb_ufm_store_ctrl;

   localparam int P   = 120;
   localparam int BTO = 400;
   localparam int RTO = 1000;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ufm_store_ctrl_if bus ();

   ufm_store_ctrl #(
      .PULSE_CYC   (P),
      .BUSY_TO_CYC (BTO),
      .READY_TO_CYC(RTO)
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   task automatic checkOutput(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Cycle k is the k-th rising edge after the accepting edge (k=0). A pin change
   // applied before edge k is acted on by the controller at edge k+2.
   function automatic void predict(input int fo, input int lo, input int fk,
                                   output int d, output int code);
      int seen_fall, seen_rise;
      seen_fall = (fo + 2 > P + 1) ? fo + 2 : P + 1;
      if (lo > 0 && seen_fall <= P + BTO) begin
         seen_rise = fo + lo + 2;
         if (seen_rise <= seen_fall + RTO) begin
            d = seen_rise;  code = 0;
         end else begin
            d = seen_fall + RTO;  code = 2;
         end
      end else begin
         d = P + BTO;  code = 1;
      end
      if (fk >= 0 && fk + 2 >= P + 1 && fk + 2 <= d) begin
         d = fk + 2;  code = 3;
      end
   endfunction

   task automatic applyStimulus(input string name, input int fo, input int lo,
                                input int fk, input bit hold);
      int d, code, kmax;
      int low_cnt = 0, last_low = -1, done_cnt = 0, done_at = -1;
      int busy_k0 = 0, err_k0 = 1, busy_d = 0, busy_d1 = 1, err_d1 = 0, code_d = 0, code_d1 = 0;
      predict(fo, lo, fk, d, code);
      kmax = d;
      if (fo + lo > kmax) kmax = fo + lo;
      if (fk > kmax) kmax = fk;
      kmax += 4;
      for (int k = 0; k <= kmax; k++) begin
         @(negedge clk);
         bus.start    = (k == 0) || (hold && k <= d);
         bus.ufmbusyn = !(lo > 0 && k >= fo && k < fo + lo);
         bus.ufmfail  = (k == fk);
         @(posedge clk);
         #1;
         if (!bus.storen) begin
            low_cnt++;
            last_low = k;
         end
         if (bus.done) begin
            done_cnt++;
            if (done_at < 0) done_at = k;
         end
         if (k == 0) begin
            busy_k0 = int'(bus.busy);
            err_k0  = int'(bus.err);
         end
         if (k == d) begin
            busy_d = int'(bus.busy);
            code_d = int'(bus.err_code);
         end
         if (k == d + 1) begin
            busy_d1 = int'(bus.busy);
            err_d1  = int'(bus.err);
            code_d1 = int'(bus.err_code);
         end
      end
      bus.start = 1'b0;
      checkOutput({name, ":busy_at_accept"}, busy_k0, 1);
      checkOutput({name, ":err_cleared"}, err_k0, 0);
      checkOutput({name, ":storen_low_cycles"}, low_cnt, P);
      checkOutput({name, ":storen_last_low"}, last_low, P - 1);
      checkOutput({name, ":done_count"}, done_cnt, 1);
      checkOutput({name, ":done_cycle"}, done_at, d);
      checkOutput({name, ":busy_in_finish"}, busy_d, 1);
      checkOutput({name, ":err_code"}, code_d, code);
      checkOutput({name, ":busy_after"}, busy_d1, 0);
      checkOutput({name, ":err_sticky"}, err_d1, (code != 0) ? 1 : 0);
      checkOutput({name, ":code_sticky"}, code_d1, code);
   endtask

   task automatic dropWhileBusy();
      int busy_seen = 0, low_seen = 0;
      @(negedge clk);
      bus.ufmbusyn = 1'b0;
      repeat (3) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         busy_seen += int'(bus.busy);
         low_seen  += int'(!bus.storen);
      end
      @(negedge clk);
      bus.ufmbusyn = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("drop:busy", busy_seen, 0);
      checkOutput("drop:storen", low_seen, 0);
   endtask

   task automatic resetMidPulse();
      int done_seen = 0, busy_seen = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         bus.start = (k == 0);
      end
      @(negedge clk);
      rstn = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rst:storen", int'(bus.storen), 1);
      checkOutput("rst:busy", int'(bus.busy), 0);
      checkOutput("rst:done", int'(bus.done), 0);
      @(negedge clk);
      rstn = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         #1;
         done_seen += int'(bus.done);
         busy_seen += int'(bus.busy);
      end
      checkOutput("rst:no_done", done_seen, 0);
      checkOutput("rst:stays_idle", busy_seen, 0);
   endtask

   initial begin
      int kind, fo, lo, fk;
      bus.start    = 1'b0;
      bus.ufmbusyn = 1'b1;
      bus.ufmfail  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset:storen", int'(bus.storen), 1);
      checkOutput("reset:busy", int'(bus.busy), 0);
      checkOutput("reset:done", int'(bus.done), 0);
      checkOutput("reset:err", int'(bus.err), 0);
      checkOutput("reset:err_code", int'(bus.err_code), 0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);

      applyStimulus("nominal", 150, 200, -1, 1'b0);
      applyStimulus("busy_tied_high", 150, 0, -1, 1'b0);
      applyStimulus("ready_timeout", 150, 1500, -1, 1'b0);
      applyStimulus("fail_at_release", 150, 200, 350, 1'b0);
      applyStimulus("start_held", 150, 200, -1, 1'b1);
      dropWhileBusy();
      resetMidPulse();
      applyStimulus("after_reset", 150, 200, -1, 1'b0);

      for (int i = 0; i < 14; i++) begin
         kind = int'($urandom_range(0, 4));
         fk   = -1;
         case (kind)
            0: begin fo = int'($urandom_range(100, 450)); lo = int'($urandom_range(40, 900)); end
            1: begin fo = int'($urandom_range(100, 450)); lo = 0; end
            2: begin fo = int'($urandom_range(100, 300)); lo = int'($urandom_range(995, 1100)); end
            3: begin
               fo = int'($urandom_range(100, 400));
               lo = int'($urandom_range(40, 900));
               fk = int'($urandom_range(P - 10, fo + lo + 5));
            end
            default: begin fo = int'($urandom_range(510, 560)); lo = int'($urandom_range(40, 100)); end
         endcase
         applyStimulus($sformatf("rand%0d_k%0d", i, kind), fo, lo, fk, 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
